// File: rtl/commit_tracker_pkg.sv
// Shared constants for the commit tracker: FSM state encodings, the default
// trap opcode, the channel-count ceiling and the width of the per-cycle
// retire count.
package commit_tracker_pkg;

  // FSM encodings
  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_TRAP_REPORT = 2'd1;
  localparam logic [1:0] ST_HALTED      = 2'd2;

  // Default opcode field (inst[6:0]) that halts simulation
  localparam logic [6:0] TRAP_OPCODE_DEF = 7'h6b;

  // Commit channel ceiling and the width needed to count up to it
  localparam int CMT_WIDTH_MAX = 4;
  localparam int ACC_CNT_W     = 3;

endpackage : commit_tracker_pkg

// File: rtl/commit_tracker_mask_gen.sv
// commit_mask_gen: combinational accept mask, trap channel index and accepted popcount.
// Ports: in_valid/in_op per channel in, trap_en in; accept_mask, trap_hit, trap_idx, acc_cnt out.
// Zero latency (pure combinational); no backpressure.
module commit_mask_gen
  import commit_tracker_pkg::*;
#(
  parameter int         CMT_WIDTH   = 2,
  parameter logic [6:0] TRAP_OPCODE = TRAP_OPCODE_DEF,
  parameter int         IDX_W       = (CMT_WIDTH > 1) ? $clog2(CMT_WIDTH) : 1
) (
  input  logic [CMT_WIDTH-1:0]   in_valid,
  input  logic [CMT_WIDTH*7-1:0] in_op,
  input  logic                   trap_en,
  output logic [CMT_WIDTH-1:0]   accept_mask,
  output logic                   trap_hit,
  output logic [IDX_W-1:0]       trap_idx,
  output logic [ACC_CNT_W-1:0]   acc_cnt
);

  // live stays high while every lower channel was valid and none of them trapped
  logic live;

  always_comb begin
    accept_mask = '0;
    trap_hit    = 1'b0;
    trap_idx    = '0;
    acc_cnt     = '0;
    live        = 1'b1;
    for (int i = 0; i < CMT_WIDTH; i++) begin
      if (live && in_valid[i]) begin
        accept_mask[i] = 1'b1;
        acc_cnt        = acc_cnt + 1'b1;
        // The trapping channel itself commits; everything above it is dropped
        if (trap_en && (in_op[i*7 +: 7] == TRAP_OPCODE)) begin
          trap_hit = 1'b1;
          trap_idx = IDX_W'(i);
          live     = 1'b0;
        end
      end else begin
        live = 1'b0;
      end
    end
  end

endmodule : commit_mask_gen

// File: rtl/commit_tracker.sv
// commit_tracker: registers retire channels, detects trap, halts, keeps perf counters.
// Ports: in_* retire bundle, trap_code_in, perf_clean in; cmt_* commit bundle, trap/halt status, cycle/instr counters out.
// One cycle latency on every commit output; no backpressure, HALTED drops all input until reset.
module commit_tracker
  import commit_tracker_pkg::*;
#(
  parameter int         CMT_WIDTH   = 2,
  parameter int         XLEN        = 64,
  parameter logic [6:0] TRAP_OPCODE = TRAP_OPCODE_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CMT_WIDTH-1:0]      in_valid,
  input  logic [CMT_WIDTH*XLEN-1:0] in_pc,
  input  logic [CMT_WIDTH*32-1:0]   in_inst,
  input  logic [CMT_WIDTH-1:0]      in_wen,
  input  logic [CMT_WIDTH-1:0]      in_skip,
  input  logic [CMT_WIDTH*5-1:0]    in_wdest,
  input  logic [CMT_WIDTH*XLEN-1:0] in_wdata,
  input  logic [7:0]                trap_code_in,
  input  logic                      perf_clean,
  output logic [CMT_WIDTH-1:0]      cmt_valid,
  output logic [CMT_WIDTH-1:0]      cmt_wen,
  output logic [CMT_WIDTH-1:0]      cmt_skip,
  output logic [CMT_WIDTH*XLEN-1:0] cmt_pc,
  output logic [CMT_WIDTH*32-1:0]   cmt_inst,
  output logic [CMT_WIDTH*XLEN-1:0] cmt_wdata,
  output logic [CMT_WIDTH*8-1:0]    cmt_wdest,
  output logic                      trap_valid,
  output logic [7:0]                trap_code,
  output logic [XLEN-1:0]           trap_pc,
  output logic                      halted,
  output logic [63:0]               cycle_cnt,
  output logic [63:0]               instr_cnt
);

  localparam int IDX_W = (CMT_WIDTH > 1) ? $clog2(CMT_WIDTH) : 1;

  logic [1:0]                state_q, state_d;
  logic [CMT_WIDTH-1:0]      cmt_valid_q, cmt_valid_d;
  logic [CMT_WIDTH-1:0]      cmt_wen_q, cmt_wen_d;
  logic [CMT_WIDTH-1:0]      cmt_skip_q, cmt_skip_d;
  logic [CMT_WIDTH*XLEN-1:0] cmt_pc_q, cmt_pc_d;
  logic [CMT_WIDTH*32-1:0]   cmt_inst_q, cmt_inst_d;
  logic [CMT_WIDTH*XLEN-1:0] cmt_wdata_q, cmt_wdata_d;
  logic [CMT_WIDTH*8-1:0]    cmt_wdest_q, cmt_wdest_d;
  logic [7:0]                trap_code_q, trap_code_d;
  logic [XLEN-1:0]           trap_pc_q, trap_pc_d;
  logic [63:0]               cycle_cnt_q, cycle_cnt_d;
  logic [63:0]               instr_cnt_q, instr_cnt_d;

  logic [CMT_WIDTH*7-1:0]    in_op;
  logic [CMT_WIDTH-1:0]      accept_mask;
  logic                      trap_hit;
  logic [IDX_W-1:0]          trap_idx;
  logic [ACC_CNT_W-1:0]      acc_cnt;
  logic                      st_run;
  logic                      st_halted;

  assign st_run    = (state_q == ST_RUN);
  assign st_halted = (state_q == ST_HALTED);

  // Only the opcode field of each instruction matters for trap detection
  always_comb begin
    in_op = '0;
    for (int i = 0; i < CMT_WIDTH; i++) begin
      in_op[i*7 +: 7] = in_inst[i*32 +: 7];
    end
  end

  commit_mask_gen #(
    .CMT_WIDTH   (CMT_WIDTH),
    .TRAP_OPCODE (TRAP_OPCODE),
    .IDX_W       (IDX_W)
  ) u_mask_gen (
    .in_valid    (in_valid),
    .in_op       (in_op),
    .trap_en     (st_run),
    .accept_mask (accept_mask),
    .trap_hit    (trap_hit),
    .trap_idx    (trap_idx),
    .acc_cnt     (acc_cnt)
  );

  // Commit bundle: payload always passes through, valid/wen gated by mask and state
  always_comb begin
    cmt_pc_d    = in_pc;
    cmt_inst_d  = in_inst;
    cmt_wdata_d = in_wdata;
    cmt_skip_d  = in_skip;
    cmt_valid_d = st_halted ? '0 : accept_mask;
    cmt_wen_d   = '0;
    cmt_wdest_d = '0;
    for (int i = 0; i < CMT_WIDTH; i++) begin
      cmt_wdest_d[i*8 +: 8] = {3'b000, in_wdest[i*5 +: 5]};
      // x0 writes are architecturally discarded, so never report them
      cmt_wen_d[i] = cmt_valid_d[i] & in_wen[i] & (in_wdest[i*5 +: 5] != 5'd0);
    end
  end

  // FSM, trap capture and performance counters
  always_comb begin
    state_d     = state_q;
    trap_code_d = trap_code_q;
    trap_pc_d   = trap_pc_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (trap_hit) begin
          state_d     = ST_TRAP_REPORT;
          trap_code_d = trap_code_in;
          trap_pc_d   = in_pc[trap_idx*XLEN +: XLEN];
        end
      end
      ST_TRAP_REPORT: state_d = ST_HALTED;
      ST_HALTED:      state_d = ST_HALTED;
      default:        state_d = ST_RUN;
    endcase

    // Counters freeze once halted; a clear wins over that cycle's increment
    if (!st_halted) begin
      if (perf_clean) begin
        cycle_cnt_d = '0;
        instr_cnt_d = '0;
      end else begin
        cycle_cnt_d = cycle_cnt_q + 64'd1;
        if (st_run) begin
          instr_cnt_d = instr_cnt_q + {{(64-ACC_CNT_W){1'b0}}, acc_cnt};
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      cmt_valid_q <= '0;
      cmt_wen_q   <= '0;
      cmt_skip_q  <= '0;
      cmt_pc_q    <= '0;
      cmt_inst_q  <= '0;
      cmt_wdata_q <= '0;
      cmt_wdest_q <= '0;
      trap_code_q <= '0;
      trap_pc_q   <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cmt_valid_q <= cmt_valid_d;
      cmt_wen_q   <= cmt_wen_d;
      cmt_skip_q  <= cmt_skip_d;
      cmt_pc_q    <= cmt_pc_d;
      cmt_inst_q  <= cmt_inst_d;
      cmt_wdata_q <= cmt_wdata_d;
      cmt_wdest_q <= cmt_wdest_d;
      trap_code_q <= trap_code_d;
      trap_pc_q   <= trap_pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cmt_valid  = cmt_valid_q;
  assign cmt_wen    = cmt_wen_q;
  assign cmt_skip   = cmt_skip_q;
  assign cmt_pc     = cmt_pc_q;
  assign cmt_inst   = cmt_inst_q;
  assign cmt_wdata  = cmt_wdata_q;
  assign cmt_wdest  = cmt_wdest_q;
  assign trap_code  = trap_code_q;
  assign trap_pc    = trap_pc_q;
  assign trap_valid = (state_q == ST_TRAP_REPORT) || st_halted;
  assign halted     = st_halted;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;

endmodule : commit_tracker

// File: tb/tb_commit_tracker.sv
// Directed bench for commit_tracker with two channels and 64-bit XLEN.
// Drives a short hand-computed sequence and compares outputs 1ns after each edge.
module tb_commit_tracker;

  localparam int CW = 2;
  localparam int XL = 64;

  logic           clock;
  logic           reset_n;
  logic [CW-1:0]  in_valid;
  logic [CW*XL-1:0] in_pc;
  logic [CW*32-1:0] in_inst;
  logic [CW-1:0]  in_wen;
  logic [CW-1:0]  in_skip;
  logic [CW*5-1:0] in_wdest;
  logic [CW*XL-1:0] in_wdata;
  logic [7:0]     trap_code_in;
  logic           perf_clean;
  logic [CW-1:0]  cmt_valid;
  logic [CW-1:0]  cmt_wen;
  logic [CW-1:0]  cmt_skip;
  logic [CW*XL-1:0] cmt_pc;
  logic [CW*32-1:0] cmt_inst;
  logic [CW*XL-1:0] cmt_wdata;
  logic [CW*8-1:0] cmt_wdest;
  logic           trap_valid;
  logic [7:0]     trap_code;
  logic [XL-1:0]  trap_pc;
  logic           halted;
  logic [63:0]    cycle_cnt;
  logic [63:0]    instr_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h0000_006b;

  commit_tracker #(.CMT_WIDTH(CW), .XLEN(XL), .TRAP_OPCODE(7'h6b)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_wen       (in_wen),
    .in_skip      (in_skip),
    .in_wdest     (in_wdest),
    .in_wdata     (in_wdata),
    .trap_code_in (trap_code_in),
    .perf_clean   (perf_clean),
    .cmt_valid    (cmt_valid),
    .cmt_wen      (cmt_wen),
    .cmt_skip     (cmt_skip),
    .cmt_pc       (cmt_pc),
    .cmt_inst     (cmt_inst),
    .cmt_wdata    (cmt_wdata),
    .cmt_wdest    (cmt_wdest),
    .trap_valid   (trap_valid),
    .trap_code    (trap_code),
    .trap_pc      (trap_pc),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .instr_cnt    (instr_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's worth of retire inputs
  task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] wen, input logic [4:0] wd0, input logic [4:0] wd1,
                       input logic [7:0] tcode, input logic pclean);
    in_valid     = v;
    in_pc        = {pc1, pc0};
    in_inst      = {i1, i0};
    in_wen       = wen;
    in_skip      = 2'b10;
    in_wdest     = {wd1, wd0};
    in_wdata     = {pc1 ^ 64'hffff, pc0 ^ 64'hffff};
    trap_code_in = tcode;
    perf_clean   = pclean;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(2'b11, 64'h1000, 64'h1004, NOP, NOP, 2'b11, 5'd5, 5'd6, 8'h00, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    // Held in reset: everything zero even with active inputs
    chk("rst_cmt_valid", 64'(cmt_valid), 64'h0);
    chk("rst_trap_valid", 64'(trap_valid), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instr", instr_cnt, 64'd0);
    reset_n = 1'b1;

    // Two clean commits
    step();
    chk("both_valid", 64'(cmt_valid), 64'h3);
    chk("both_pc1", cmt_pc[127:64], 64'h1004);
    chk("both_wdest", 64'(cmt_wdest), 64'h0605);
    chk("both_wen", 64'(cmt_wen), 64'h3);
    chk("both_skip", 64'(cmt_skip), 64'h2);
    chk("both_instr", instr_cnt, 64'd2);
    chk("both_cycle", cycle_cnt, 64'd1);

    // Gap at channel 0 drops channel 1
    drive(2'b10, 64'h2000, 64'h2004, NOP, NOP, 2'b11, 5'd5, 5'd6, 8'h00, 1'b0);
    step();
    chk("gap_valid", 64'(cmt_valid), 64'h0);
    chk("gap_wen", 64'(cmt_wen), 64'h0);
    chk("gap_pc1", cmt_pc[127:64], 64'h2004);
    chk("gap_instr", instr_cnt, 64'd2);
    chk("gap_cycle", cycle_cnt, 64'd2);

    // Write to x0 suppresses wen on ch0 only
    drive(2'b11, 64'h3000, 64'h3004, NOP, NOP, 2'b11, 5'd0, 5'd7, 8'h00, 1'b0);
    step();
    chk("x0_valid", 64'(cmt_valid), 64'h3);
    chk("x0_wen", 64'(cmt_wen), 64'h2);
    chk("x0_instr", instr_cnt, 64'd4);

    // Single channel
    drive(2'b01, 64'h3100, 64'h3104, NOP, NOP, 2'b00, 5'd1, 5'd2, 8'h00, 1'b0);
    step();
    chk("one_valid", 64'(cmt_valid), 64'h1);
    chk("one_instr", instr_cnt, 64'd5);
    chk("one_cycle", cycle_cnt, 64'd4);

    // Clear beats increment
    drive(2'b11, 64'h4000, 64'h4004, NOP, NOP, 2'b11, 5'd1, 5'd2, 8'h00, 1'b1);
    step();
    chk("clr_valid", 64'(cmt_valid), 64'h3);
    chk("clr_cycle", cycle_cnt, 64'd0);
    chk("clr_instr", instr_cnt, 64'd0);

    drive(2'b11, 64'h5000, 64'h5004, NOP, NOP, 2'b11, 5'd1, 5'd2, 8'h00, 1'b0);
    step();
    chk("post_clr_cycle", cycle_cnt, 64'd1);
    chk("post_clr_instr", instr_cnt, 64'd2);

    // Trap on ch0 masks ch1
    drive(2'b11, 64'h8000, 64'h8004, TRAP, NOP, 2'b11, 5'd1, 5'd2, 8'h00, 1'b0);
    step();
    chk("trap0_valid", 64'(cmt_valid), 64'h1);
    chk("trap0_wen", 64'(cmt_wen), 64'h1);
    chk("trap0_tvalid", 64'(trap_valid), 64'h1);
    chk("trap0_halted", 64'(halted), 64'h0);
    chk("trap0_pc", trap_pc, 64'h8000);
    chk("trap0_code", 64'(trap_code), 64'h0);
    chk("trap0_instr", instr_cnt, 64'd3);
    chk("trap0_cycle", cycle_cnt, 64'd2);

    // TRAP_REPORT -> HALTED; cycle counts in TRAP_REPORT
    drive(2'b00, 64'h9000, 64'h9004, NOP, NOP, 2'b00, 5'd1, 5'd2, 8'h33, 1'b0);
    step();
    chk("halt_halted", 64'(halted), 64'h1);
    chk("halt_tvalid", 64'(trap_valid), 64'h1);
    chk("halt_cycle", cycle_cnt, 64'd3);
    chk("halt_instr", instr_cnt, 64'd3);

    // Halted ignores commits and clears
    drive(2'b11, 64'ha000, 64'ha004, NOP, NOP, 2'b11, 5'd1, 5'd2, 8'h44, 1'b1);
    step();
    chk("frz_valid", 64'(cmt_valid), 64'h0);
    chk("frz_wen", 64'(cmt_wen), 64'h0);
    chk("frz_cycle", cycle_cnt, 64'd3);
    chk("frz_instr", instr_cnt, 64'd3);
    chk("frz_trap_pc", trap_pc, 64'h8000);
    chk("frz_code", 64'(trap_code), 64'h0);
    chk("frz_halted", 64'(halted), 64'h1);

    // Asynchronous reset mid-cycle while halted
    reset_n = 1'b0;
    #1;
    chk("areset_tvalid", 64'(trap_valid), 64'h0);
    chk("areset_halted", 64'(halted), 64'h0);
    chk("areset_cycle", cycle_cnt, 64'd0);
    chk("areset_instr", instr_cnt, 64'd0);
    chk("areset_trap_pc", trap_pc, 64'h0);
    #1;
    reset_n = 1'b1;
    drive(2'b11, 64'h100, 64'h104, NOP, NOP, 2'b11, 5'd3, 5'd4, 8'h00, 1'b0);
    step();
    chk("resume_valid", 64'(cmt_valid), 64'h3);
    chk("resume_pc0", cmt_pc[63:0], 64'h100);
    chk("resume_instr", instr_cnt, 64'd2);
    chk("resume_cycle", cycle_cnt, 64'd1);

    // Trap on ch1 with nonzero code
    drive(2'b11, 64'h200, 64'h204, NOP, TRAP, 2'b11, 5'd3, 5'd4, 8'h5a, 1'b0);
    step();
    chk("trap1_valid", 64'(cmt_valid), 64'h3);
    chk("trap1_tvalid", 64'(trap_valid), 64'h1);
    chk("trap1_pc", trap_pc, 64'h204);
    chk("trap1_code", 64'(trap_code), 64'h5a);
    chk("trap1_instr", instr_cnt, 64'd4);
    chk("trap1_wdata0", cmt_wdata[63:0], 64'h200 ^ 64'hffff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_commit_tracker
